// File: rtl/instr_pair_queue.sv
// ---------------------------------------------------------------------------
// instr_pair_queue
//
// Small FIFO placed between uop fetch and scalar decode. Fetch delivers
// instructions in pairs; decode consumes one instruction per cycle. Each
// stored pair is drained slot 1 first, then slot 2. The entry is retired
// only after its slot-2 instruction has been consumed.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   clear         synchronous flush of all queued instructions
//   in_valid      fetch presents a pair this cycle
//   in_instr_1    older instruction of the presented pair
//   in_instr_2    younger instruction of the presented pair
//   stalled       queue full, fetch must hold its pair
//   out_valid     out_instr carries a valid instruction
//   out_instr     instruction presented to decode (0 when empty)
//   out_slot      0 = out_instr is slot 1 of the head, 1 = slot 2
//   next_stalled  decode cannot consume this cycle
//   count         occupied pair entries, including a partially drained head
// ---------------------------------------------------------------------------
module instr_pair_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instr_1,
  input  logic [WIDTH-1:0]           in_instr_2,
  output logic                       stalled,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_instr,
  output logic                       out_slot,
  input  logic                       next_stalled,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Which slot of the head entry is currently being presented to decode.
  typedef enum logic {
    HALF_SLOT1 = 1'b0,
    HALF_SLOT2 = 1'b1
  } half_t;

  logic [WIDTH-1:0] storage_1 [DEPTH];
  logic [WIDTH-1:0] storage_2 [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  half_t            half;

  logic push;
  logic pop_half;
  logic retire;
  logic flush;

  assign stalled   = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_slot  = (half == HALF_SLOT2);

  // No bypass from the inputs: the presented instruction always comes from
  // storage, so a freshly pushed pair shows up one cycle after its push.
  always_comb begin
    out_instr = '0;
    if (out_valid) begin
      out_instr = (half == HALF_SLOT2) ? storage_2[rd_ptr] : storage_1[rd_ptr];
    end
  end

  // A full queue refuses pushes even if the head retires in the same cycle,
  // which keeps stalled a pure function of registered state.
  assign flush    = reset || clear;
  assign push     = in_valid && !stalled;
  assign pop_half = out_valid && !next_stalled;
  assign retire   = pop_half && (half == HALF_SLOT2);

  // Pair storage carries no reset; stale contents are never visible because
  // out_instr is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      storage_1[wr_ptr] <= in_instr_1;
      storage_2[wr_ptr] <= in_instr_2;
    end
  end

  // Pointer, occupancy and half-slot bookkeeping. Reset and clear share the
  // same path so a mid-drain reset also discards a pending slot-2 instruction.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      half   <= HALF_SLOT1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_half) begin
        if (half == HALF_SLOT1) begin
          half <= HALF_SLOT2;
        end else begin
          half   <= HALF_SLOT1;
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
      case ({push, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_pair_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_pair_queue
//
// Directed testbench for instr_pair_queue. A reference model keeps the queued
// instruction stream as a flat queue of {slot, instr} words; every cycle the
// DUT outputs are compared against it, and directed sequences add literal
// expectations at key points.
// ---------------------------------------------------------------------------
module tb_instr_pair_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_instr_1 = '0;
  logic [WIDTH-1:0] in_instr_2 = '0;
  logic             next_stalled = 1'b0;
  logic             stalled;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic             out_slot;
  logic [CW-1:0]    count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Flat model of the instruction stream still owed to decode.
  logic [WIDTH:0] mq[$];

  instr_pair_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_instr_1   (in_instr_1),
    .in_instr_2   (in_instr_2),
    .stalled      (stalled),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_slot     (out_slot),
    .next_stalled (next_stalled),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Pairs owed = instructions owed rounded up to whole pairs.
  function automatic int model_count();
    return (mq.size() + 1) / 2;
  endfunction

  function automatic bit model_full();
    return model_count() == DEPTH;
  endfunction

  task automatic check_val(input string name, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge from the pre-edge state and inputs.
  always @(posedge clk) begin
    if (reset || clear) begin
      mq.delete();
    end else begin
      bit full_now;
      full_now = model_full();
      if (mq.size() != 0 && !next_stalled) void'(mq.pop_front());
      if (in_valid && !full_now) begin
        mq.push_back({1'b0, in_instr_1});
        mq.push_back({1'b1, in_instr_2});
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      logic [WIDTH:0] head;
      head = (mq.size() != 0) ? mq[0] : '0;
      check_val("m_out_valid", WIDTH'(out_valid), WIDTH'(mq.size() != 0));
      check_val("m_stalled",   WIDTH'(stalled),   WIDTH'(model_full()));
      check_val("m_count",     WIDTH'(count),     WIDTH'(model_count()));
      check_val("m_out_instr", out_instr,         head[WIDTH-1:0]);
      check_val("m_out_slot",  WIDTH'(out_slot),  WIDTH'(head[WIDTH]));
    end
  end

  // Drive one cycle's inputs, then advance past the next edge.
  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] i1,
                                input logic [WIDTH-1:0] i2, input logic ns,
                                input logic clr, input logic rst);
    in_valid     = v;
    in_instr_1   = i1;
    in_instr_2   = i2;
    next_stalled = ns;
    clear        = clr;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic v, input logic st,
                              input logic [WIDTH-1:0] instr, input logic slot,
                              input int cnt);
    check_val({name, ".out_valid"}, WIDTH'(out_valid), WIDTH'(v));
    check_val({name, ".stalled"},   WIDTH'(stalled),   WIDTH'(st));
    check_val({name, ".out_instr"}, out_instr,         instr);
    check_val({name, ".out_slot"},  WIDTH'(out_slot),  WIDTH'(slot));
    check_val({name, ".count"},     WIDTH'(count),     WIDTH'(cnt));
  endtask

  function automatic logic [WIDTH-1:0] stream_word(input int k, input int s);
    return 32'h3000_0000 | WIDTH'(k << 8) | WIDTH'(s);
  endfunction

  logic [WIDTH-1:0] drain_exp [8];
  int k, got, cyc;
  bit acc;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and single pair
    @(posedge clk); #1;
    apply_stimulus(0, '0, '0, 0, 0, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_en = 1'b1;
    check_output("reset", 0, 0, '0, 0, 0);
    apply_stimulus(1, 32'h1111_1111, 32'h2222_2222, 0, 0, 0);
    check_output("single_s1", 1, 0, 32'h1111_1111, 0, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("single_s2", 1, 0, 32'h2222_2222, 1, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("single_done", 0, 0, '0, 0, 0);

    // Fill to full with decode stalled, then drain
    for (int i = 0; i < 4; i++)
      apply_stimulus(1, 32'hA000_0001 + (i << 8), 32'hA000_0002 + (i << 8), 1, 0, 0);
    check_output("full", 1, 1, 32'hA000_0001, 0, 4);
    apply_stimulus(1, 32'hEEEE_0001, 32'hEEEE_0002, 1, 0, 0);
    check_output("full_reject", 1, 1, 32'hA000_0001, 0, 4);
    for (int i = 0; i < 4; i++) begin
      drain_exp[2*i]   = 32'hA000_0001 + (i << 8);
      drain_exp[2*i+1] = 32'hA000_0002 + (i << 8);
    end
    for (int i = 0; i < 8; i++) begin
      check_val("drain_instr",   out_instr,        drain_exp[i]);
      check_val("drain_stalled", WIDTH'(stalled),  WIDTH'(i < 2));
      apply_stimulus(0, '0, '0, 0, 0, 0);
    end
    check_output("drain_done", 0, 0, '0, 0, 0);

    // Continuous streaming across pointer wrap
    k = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      if (out_valid) begin
        check_val("stream", out_instr, stream_word(got / 2, (got % 2) + 1));
        got++;
      end
      acc = (k < 10) && !model_full();
      apply_stimulus(k < 10, stream_word(k, 1), stream_word(k, 2), 0, 0, 0);
      if (acc) k++;
      cyc++;
    end
    n_cmp++;
    if (got != 20) begin
      n_fail++;
      $display("[TB] FAIL stream_timeout: got %0d expected 20", got);
    end
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("stream_done", 0, 0, '0, 0, 0);

    // Hold mid-pair with decode stalled
    apply_stimulus(1, 32'hB000_0001, 32'hB000_0002, 1, 0, 0);
    apply_stimulus(1, 32'hB000_0101, 32'hB000_0102, 1, 0, 0);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, '0, '0, 1, 0, 0);
      check_output("hold", 1, 0, 32'hB000_0002, 1, 2);
    end
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("hold_release", 1, 0, 32'hB000_0101, 0, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("hold_done", 0, 0, '0, 0, 0);

    // Clear with a pair presented in the same cycle
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, 32'hC000_0001 + (i << 8), 32'hC000_0002 + (i << 8), 1, 0, 0);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("pre_clear", 1, 0, 32'hC000_0002, 1, 3);
    apply_stimulus(1, 32'hDEAD_0001, 32'hDEAD_0002, 0, 1, 0);
    check_output("clear", 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, '0, '0, 0, 0, 0);
      check_output("post_clear", 0, 0, '0, 0, 0);
    end

    // Reset while two pairs are queued
    apply_stimulus(1, 32'hF000_0001, 32'hF000_0002, 1, 0, 0);
    apply_stimulus(1, 32'hF000_0101, 32'hF000_0102, 1, 0, 0);
    check_output("pre_reset", 1, 0, 32'hF000_0001, 0, 2);
    apply_stimulus(0, '0, '0, 0, 0, 1);
    check_output("mid_reset", 0, 0, '0, 0, 0);
    apply_stimulus(1, 32'h5555_0001, 32'h5555_0002, 0, 0, 0);
    check_output("after_reset", 1, 0, 32'h5555_0001, 0, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("after_reset_s2", 1, 0, 32'h5555_0002, 1, 1);
    apply_stimulus(0, '0, '0, 0, 0, 0);
    check_output("final_idle", 0, 0, '0, 0, 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_pair_queue.md
Name: instr_pair_queue

Overview:
- Sits directly downstream of the uop fetch stage.
- Accepts 64-bit instruction pairs (instruction_1, instruction_2) into a small FIFO.
- Serializes each pair into a single-instruction stream for the scalar decode stage: slot 1 first, then slot 2.
- Provides backpressure to fetch through stalled and supports a pipeline-wide clear (flush).

Parameters:
- DEPTH, 4, number of pair entries; must be a power of two and >= 2.
- WIDTH, 32, width of one instruction.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- clear  input  1  synchronous flush of all queued instructions
- in_valid  input  1  fetch presents a pair (connects to fetch valid)
- in_instr_1  input  WIDTH  first (older) instruction of pair
- in_instr_2  input  WIDTH  second (younger) instruction of pair
- stalled  output  1  queue cannot accept a pair this cycle (connects to fetch next_stalled)
- out_valid  output  1  out_instr holds a valid instruction
- out_instr  output  WIDTH  instruction presented to decode
- out_slot  output  1  0 = out_instr came from slot 1, 1 = from slot 2
- next_stalled  input  1  decode cannot consume this cycle
- count  output  $clog2(DEPTH+1)  occupied pair entries, including a partially drained head

Behaviour:
- State:
  - storage[DEPTH] of {instr_1, instr_2}
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
  - half register: 0 = head slot 1 pending, 1 = head slot 2 pending
- Reset: wr_ptr = rd_ptr = 0, count = 0, half = 0. Storage contents are don't-care.
  - Resulting outputs: out_valid = 0, stalled = 0, out_instr = 0, out_slot = 0.
- Combinational outputs:
  - stalled = (count == DEPTH).
  - out_valid = (count != 0).
  - out_instr = half ? storage[rd_ptr].instr_2 : storage[rd_ptr].instr_1, forced to 0 when count == 0.
  - out_slot = half.
- Push: occurs at a clock edge when in_valid && !stalled. Writes the pair at wr_ptr and increments wr_ptr.
- Pop-half: occurs at a clock edge when out_valid && !next_stalled.
  - If half == 0: set half = 1. count is unchanged.
  - If half == 1: set half = 0, increment rd_ptr, decrement count.
- Simultaneous push and final pop-half: count is unchanged and both pointers advance.
- No fall-through path: a pair pushed at edge N is first visible on out_instr in the cycle after edge N, giving 1-cycle latency from an empty queue.
- Full: stalled is asserted while count == DEPTH. No push occurs in that cycle, even if a pop retires an entry in the same cycle. stalled deasserts the cycle after count drops.
- Empty: out_valid = 0. next_stalled is ignored. Pop is suppressed.
- Wrap-around: pointers roll from DEPTH-1 to 0 without any bubble.
- Clear: takes effect at the clock edge and has priority over push and pop in the same cycle.
  - Sets wr_ptr = rd_ptr = 0, count = 0, half = 0.
  - A pair presented in the clear cycle is dropped.
  - Outputs go idle the following cycle.
- Reset asserted mid-drain (for example half = 1) behaves exactly like clear and discards the remaining slot-2 instruction.
- Throughput:
  - Output rate is at most 1 instruction per cycle, i.e. 0.5 pair per cycle.
  - A fetch that is never stalled fills the queue and then sees stalled roughly every other cycle.

Test Plan:
- Reset, then push pair {1=0x11111111, 2=0x22222222} with next_stalled=0 -> cycle+1 out_instr=0x11111111 out_slot=0; cycle+2 out_instr=0x22222222 out_slot=1; cycle+3 out_valid=0, count=0.
- Push 4 pairs back-to-back with next_stalled=1 -> count reaches 4, stalled=1, 5th pair not accepted. Release next_stalled -> 8 instructions emerge in order 1a,2a,1b,2b,...; stalled drops after the first entry retires.
- Continuous push of 10 distinct pairs while consuming -> all 20 instructions emerge in order with no loss or duplication across the pointer wrap 3->0.
- Hold out_valid=1 with next_stalled=1 for 5 cycles mid-pair (half=1) -> out_instr stays at slot-2 value and count is unchanged; release -> continues with next pair's slot 1.
- Queue holding 3 pairs with half=1, assert clear together with in_valid=1 -> next cycle count=0, out_valid=0, stalled=0; the presented pair never appears.
- Assert reset while count=2 and next_stalled=0 -> next cycle all outputs at reset values, count=0; next push appears at slot 1 after 1 cycle.
